// File: rtl/sblk_pkg.sv
// Shared constants and types for the superblock activation path.
package sblk_pkg;

    localparam int WID_ACT = 16;
    localparam int N_ROW   = 4;

    typedef logic [2*WID_ACT-1:0] act_word_t;

endpackage

// File: rtl/act_fifo.sv
// Single-clock first-word-fall-through FIFO feeding one superblock row.
// While empty, dout keeps showing the last word that was popped.
module act_fifo
    import sblk_pkg::*;
#(
    parameter int WIDTH = 2*WID_ACT,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? last_q : mem[rd_ptr];

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the held output word.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/act_row_dispatch.sv
// Activation feeder: routes an upstream word stream into per-row FIFOs,
// either round-robin in bursts or broadcast to every row.
module act_row_dispatch #(
    parameter int N_ROW      = sblk_pkg::N_ROW,
    parameter int WID_ACT    = sblk_pkg::WID_ACT,
    parameter int FIFO_DEPTH = 8,
    parameter int WID_BURST  = 8
) (
    input  logic                       clk_l,
    input  logic                       rst,
    input  logic                       cfg_load,
    input  logic [WID_BURST-1:0]       cfg_burst_len,
    input  logic                       cfg_bcast,
    input  logic [2*WID_ACT-1:0]       in_data,
    input  logic                       in_vld,
    output logic                       in_rdy,
    output logic [2*WID_ACT*N_ROW-1:0] act_data_in,
    output logic [N_ROW-1:0]           act_data_in_vld,
    input  logic [N_ROW-1:0]           act_data_in_req,
    output logic                       idle
);

    localparam int W  = 2*WID_ACT;
    localparam int PW = (N_ROW > 1) ? $clog2(N_ROW) : 1;
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0]        PTR_ONE  = PW'(1);
    localparam logic [PW-1:0]        PTR_LAST = PW'(N_ROW-1);
    localparam logic [WID_BURST-1:0] BURST_ONE = WID_BURST'(1);

    logic [PW-1:0]        row_ptr;
    logic [WID_BURST-1:0] burst_cnt;
    logic [WID_BURST-1:0] burst_len_q;
    logic                 bcast_q;
    logic                 acc;
    logic                 all_empty;

    logic [N_ROW-1:0] row_push;
    logic [N_ROW-1:0] row_pop;
    logic [N_ROW-1:0] row_full;
    logic [N_ROW-1:0] row_empty;
    logic [CW:0]      row_count [N_ROW];

    assign acc  = in_vld & in_rdy;
    assign idle = all_empty & ~in_vld;

    // Ready depends on the target row (or every row when broadcasting); held low in reset.
    always_comb begin
        in_rdy = 1'b0;
        if (!rst) begin
            if (bcast_q) begin
                in_rdy = ~|row_full;
            end else begin
                in_rdy = ~row_full[row_ptr];
            end
        end
    end

    // All rows drained when every occupancy count is zero.
    always_comb begin
        all_empty = 1'b1;
        for (int r = 0; r < N_ROW; r++) begin
            if (row_count[r] != '0) begin
                all_empty = 1'b0;
            end
        end
    end

    // Router state: burst position, current row and latched configuration.
    always_ff @(posedge clk_l) begin
        if (rst) begin
            row_ptr     <= '0;
            burst_cnt   <= '0;
            burst_len_q <= BURST_ONE;
            bcast_q     <= 1'b0;
        end else begin
            if (acc && !bcast_q) begin
                if (burst_cnt == burst_len_q - BURST_ONE) begin
                    burst_cnt <= '0;
                    row_ptr   <= (row_ptr == PTR_LAST) ? '0 : row_ptr + PTR_ONE;
                end else begin
                    burst_cnt <= burst_cnt + BURST_ONE;
                end
            end
            if (cfg_load) begin
                burst_len_q <= (cfg_burst_len == '0) ? BURST_ONE : cfg_burst_len;
                bcast_q     <= cfg_bcast;
                row_ptr     <= '0;
                burst_cnt   <= '0;
            end
        end
    end

    genvar r;
    generate
        for (r = 0; r < N_ROW; r++) begin : g_row
            assign row_push[r]        = acc & (bcast_q | (row_ptr == PW'(r)));
            assign row_pop[r]         = ~row_empty[r] & act_data_in_req[r];
            assign act_data_in_vld[r] = ~row_empty[r];

            act_fifo #(
                .WIDTH (W),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk   (clk_l),
                .rst   (rst),
                .push  (row_push[r]),
                .din   (in_data),
                .pop   (row_pop[r]),
                .dout  (act_data_in[r*W +: W]),
                .full  (row_full[r]),
                .empty (row_empty[r]),
                .count (row_count[r])
            );
        end
    endgenerate

endmodule
